// File: rtl/world_stream_loader.sv
// world_stream_loader
//   Parses the framed plugin byte stream (0xA5, opcode, payload, XOR checksum)
//   coming from the UART receiver and turns SET / FILL packets into voxel
//   write requests for the L3 block cache. The UART is never stalled: bytes
//   that arrive while a packet is being checked or emitted are dropped and
//   counted as overrun errors.
//
// Ports
//   clk_in         system clock (100 MHz), sole clock
//   rst_in         synchronous active-low reset
//   byte_in        received byte
//   byte_valid_in  one-cycle strobe qualifying byte_in
//   wr_valid_out   write request valid (held until accepted)
//   wr_ready_in    cache accepts the write
//   wr_x_out       write x coordinate
//   wr_y_out       write y coordinate
//   wr_z_out       write z coordinate
//   wr_block_out   block type to write
//   busy_out       loader is inside a packet (state != IDLE)
//   pkt_count_out  good packets, saturating at 65535
//   err_count_out  error events, saturating at 255
//   err_pulse_out  one-cycle pulse per error event
module world_stream_loader #(
   parameter int LENGTH         = 64,
   parameter int WIDTH          = 64,
   parameter int HEIGHT         = 16,
   parameter int BLOCK_WIDTH    = 5,
   parameter int TIMEOUT_CYCLES = 100_000
) (
   input  logic                       clk_in,
   input  logic                       rst_in,
   input  logic [7:0]                 byte_in,
   input  logic                       byte_valid_in,
   output logic                       wr_valid_out,
   input  logic                       wr_ready_in,
   output logic [$clog2(LENGTH)-1:0]  wr_x_out,
   output logic [$clog2(WIDTH)-1:0]   wr_y_out,
   output logic [$clog2(HEIGHT)-1:0]  wr_z_out,
   output logic [BLOCK_WIDTH-1:0]     wr_block_out,
   output logic                       busy_out,
   output logic [15:0]                pkt_count_out,
   output logic [7:0]                 err_count_out,
   output logic                       err_pulse_out
);

   localparam int XW = $clog2(LENGTH);
   localparam int YW = $clog2(WIDTH);
   localparam int ZW = $clog2(HEIGHT);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [XW-1:0] X_MAX    = XW'(LENGTH - 1);
   localparam logic [YW-1:0] Y_MAX    = YW'(WIDTH - 1);
   localparam logic [ZW-1:0] Z_MAX    = ZW'(HEIGHT - 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

   localparam logic [7:0] SYNC    = 8'hA5;
   localparam logic [7:0] OP_SET  = 8'h01;
   localparam logic [7:0] OP_FILL = 8'h02;

   typedef enum logic [2:0] {
      IDLE,
      OPCODE,
      PAYLOAD,
      CSUM,
      CHECK,
      EMIT
   } state_t;

   state_t                 state;
   state_t                 state_nxt;
   logic                   err_evt;
   logic                   is_fill;
   logic [2:0]             idx;
   logic [2:0]             last_idx;
   logic [7:0]             csum;
   logic [7:0]             pay_x;
   logic [7:0]             pay_y;
   logic [7:0]             pay_z;
   logic [BLOCK_WIDTH-1:0] pay_blk;
   logic [7:0]             pay_n;
   logic [8:0]             remaining;
   logic [TW-1:0]          tmo_cnt;
   logic                   tmo_hit;
   logic                   range_bad;
   logic                   in_packet;

   assign last_idx  = is_fill ? 3'd4 : 3'd3;
   assign in_packet = (state == OPCODE) || (state == PAYLOAD) || (state == CSUM);
   // The timeout fires on the TIMEOUT_CYCLES-th consecutive idle cycle.
   assign tmo_hit   = in_packet && !byte_valid_in && (tmo_cnt == TMO_LAST);
   assign range_bad = (32'(pay_x) >= 32'(LENGTH)) ||
                      (32'(pay_y) >= 32'(WIDTH))  ||
                      (32'(pay_z) >= 32'(HEIGHT));

   // Next state and error detection. All error sources of one cycle are
   // OR-ed into a single event so they count once.
   always_comb begin
      state_nxt = state;
      err_evt   = 1'b0;
      case (state)
         IDLE: begin
            if (byte_valid_in && byte_in == SYNC) state_nxt = OPCODE;
         end
         OPCODE: begin
            if (byte_valid_in) begin
               if (byte_in == OP_SET || byte_in == OP_FILL) begin
                  state_nxt = PAYLOAD;
               end else begin
                  err_evt   = 1'b1;
                  state_nxt = IDLE;
               end
            end else if (tmo_hit) begin
               err_evt   = 1'b1;
               state_nxt = IDLE;
            end
         end
         PAYLOAD: begin
            if (byte_valid_in) begin
               if (idx == last_idx) state_nxt = CSUM;
            end else if (tmo_hit) begin
               err_evt   = 1'b1;
               state_nxt = IDLE;
            end
         end
         CSUM: begin
            if (byte_valid_in) begin
               if (byte_in == csum) begin
                  state_nxt = CHECK;
               end else begin
                  err_evt   = 1'b1;
                  state_nxt = IDLE;
               end
            end else if (tmo_hit) begin
               err_evt   = 1'b1;
               state_nxt = IDLE;
            end
         end
         CHECK: begin
            err_evt   = byte_valid_in || range_bad;
            state_nxt = range_bad ? IDLE : EMIT;
         end
         EMIT: begin
            err_evt = byte_valid_in;
            // wr_valid_out is always high in EMIT, so ready alone means a transfer.
            if (wr_ready_in && remaining == 9'd1) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         state         <= IDLE;
         is_fill       <= 1'b0;
         idx           <= '0;
         csum          <= '0;
         pay_x         <= '0;
         pay_y         <= '0;
         pay_z         <= '0;
         pay_blk       <= '0;
         pay_n         <= '0;
         remaining     <= '0;
         tmo_cnt       <= '0;
         wr_valid_out  <= 1'b0;
         wr_x_out      <= '0;
         wr_y_out      <= '0;
         wr_z_out      <= '0;
         wr_block_out  <= '0;
         busy_out      <= 1'b0;
         pkt_count_out <= '0;
         err_count_out <= '0;
         err_pulse_out <= 1'b0;
      end else begin
         state         <= state_nxt;
         busy_out      <= (state_nxt != IDLE);
         err_pulse_out <= err_evt;

         if (err_evt && err_count_out != 8'hFF) err_count_out <= err_count_out + 8'd1;

         if (in_packet && !byte_valid_in) tmo_cnt <= tmo_cnt + 1'b1;
         else                             tmo_cnt <= '0;

         case (state)
            OPCODE: begin
               if (byte_valid_in) begin
                  is_fill <= (byte_in == OP_FILL);
                  csum    <= byte_in;
                  idx     <= '0;
               end
            end
            PAYLOAD: begin
               if (byte_valid_in) begin
                  csum <= csum ^ byte_in;
                  idx  <= idx + 3'd1;
                  case (idx)
                     3'd0:    pay_x   <= byte_in;
                     3'd1:    pay_y   <= byte_in;
                     3'd2:    pay_z   <= byte_in;
                     3'd3:    pay_blk <= byte_in[BLOCK_WIDTH-1:0];
                     default: pay_n   <= byte_in;
                  endcase
               end
            end
            CHECK: begin
               if (!range_bad) begin
                  if (pkt_count_out != 16'hFFFF) pkt_count_out <= pkt_count_out + 16'd1;
                  wr_valid_out <= 1'b1;
                  wr_x_out     <= pay_x[XW-1:0];
                  wr_y_out     <= pay_y[YW-1:0];
                  wr_z_out     <= pay_z[ZW-1:0];
                  wr_block_out <= pay_blk;
                  if (!is_fill)          remaining <= 9'd1;
                  else if (pay_n == '0)  remaining <= 9'd256;
                  else                   remaining <= {1'b0, pay_n};
               end
            end
            EMIT: begin
               if (wr_ready_in) begin
                  if (remaining == 9'd1) begin
                     wr_valid_out <= 1'b0;
                  end else begin
                     remaining <= remaining - 9'd1;
                     // y fastest, then z, then x; the whole volume wraps to origin.
                     if (wr_y_out == Y_MAX) begin
                        wr_y_out <= '0;
                        if (wr_z_out == Z_MAX) begin
                           wr_z_out <= '0;
                           wr_x_out <= (wr_x_out == X_MAX) ? '0 : wr_x_out + 1'b1;
                        end else begin
                           wr_z_out <= wr_z_out + 1'b1;
                        end
                     end else begin
                        wr_y_out <= wr_y_out + 1'b1;
                     end
                  end
               end
            end
            default: begin
               idx <= '0;
            end
         endcase
      end
   end

endmodule
